nrs_reg_ctrl: RTL and testbench
===============================

Name: nrs_reg_ctrl

Overview:
- Sequencer for the 16-bit NRS bit register that sits between the Gold-sequence generator and the resource-element mapper.
- Fills the register with WIDTH_REG consecutive c(n) bits from the Gold generator using a valid/ready handshake. The c_n data path runs directly from the generator to the register; this block only drives wr_en and wr_addr.
- Then serves the mapper one NRS complex pair per handshake: four read addresses covering bits (1r, 1i, 2r, 2i).
- One fill plus its complete serve phase forms a "block". A start pulse launches each block.

Parameters:
- WIDTH_REG, 16, register depth in bits. Must be a multiple of 4.
- LINES, $clog2(WIDTH_REG), address width.
- PAIRS, WIDTH_REG/4, mapper handshakes per block.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-low reset.
- start, input, 1, single-cycle pulse requesting a new block.
- gold_valid, input, 1, Gold generator presents a valid c(n) bit this cycle.
- gold_ready, output, 1, controller accepts a bit (high only in FILL).
- wr_en, output, 1, register write strobe.
- wr_addr, output, LINES, register write address.
- nrs_valid, output, 1, read addresses are valid for the mapper.
- map_ready, input, 1, mapper consumes the current pair.
- rd_addr_1r, rd_addr_1i, rd_addr_2r, rd_addr_2i, output, LINES each, register read addresses.
- pair_idx, output, $clog2(PAIRS) (minimum 1), index of the pair currently being served.
- busy, output, 1, high whenever the state is not IDLE.
- block_done, output, 1, one-cycle pulse after the last pair is consumed.

Behaviour:
- Reset (async, rst=0): state=IDLE; fill_cnt=0; pair_cnt=0; pending=0. Outputs: gold_ready=0, wr_en=0, wr_addr=0, nrs_valid=0, all rd_addr=0, pair_idx=0, busy=0, block_done=0.
- Reset asserted in any state aborts the operation immediately. Partial register contents are don't-care; the register has its own reset.
- FSM states: IDLE, FILL, SERVE.
- IDLE:
  - gold_ready=0, nrs_valid=0.
  - start=1 -> FILL next cycle, with fill_cnt=0.
- FILL:
  - gold_ready=1.
  - wr_en = gold_valid (combinational). wr_addr = fill_cnt (registered counter).
  - Each cycle with gold_valid=1: fill_cnt increments.
  - On the write where fill_cnt=WIDTH_REG-1: fill_cnt wraps to 0, state -> SERVE, pair_cnt=0.
  - gold_valid=0 stalls the fill: no write, counter holds.
  - start during FILL is ignored.
- SERVE:
  - nrs_valid=1, gold_ready=0, wr_en=0.
  - rd_addr_1r=4*pair_cnt, rd_addr_1i=4*pair_cnt+1, rd_addr_2r=4*pair_cnt+2, rd_addr_2i=4*pair_cnt+3. All are combinational from the registered pair_cnt.
  - pair_idx = pair_cnt.
  - nrs_valid & map_ready: pair_cnt increments.
  - If pair_cnt=PAIRS-1 at that handshake: block_done=1 for the next cycle, pair_cnt resets to 0, then:
    - pending=1 -> FILL (pending cleared);
    - otherwise -> IDLE.
  - map_ready=0 holds the addresses stable and nrs_valid high.
- Latency:
  - First write occurs in the cycle after start, provided gold_valid=1.
  - With no stalls, nrs_valid rises WIDTH_REG+1 cycles after start.
  - Each pair is served in one cycle when map_ready=1.
- Pending start:
  - start during SERVE sets pending=1. Further starts while pending=1 are dropped; there is no queueing beyond one.
  - start in the same cycle as the final SERVE handshake also sets pending, so the block goes straight to FILL.
- block_done registered pulse: asserted in the first cycle of the following IDLE or FILL state.
- Address arithmetic: LINES-bit unsigned. 4*pair_cnt+3 ≤ WIDTH_REG-1 always holds, so there is no wrap.
- A write and a read never overlap in the same cycle, because FILL and SERVE are exclusive.

Test Plan:
1. Reset, then start pulse, gold_valid held 1 with bits 0xA5C3 LSB first. Required: wr_addr steps 0..15 on 16 consecutive cycles; nrs_valid rises 17 cycles after start; the register reads back 0xA5C3.
2. SERVE with map_ready=1 continuously. Required: address sets (0,1,2,3), (4,5,6,7), (8,9,10,11), (12,13,14,15) on 4 consecutive cycles; block_done pulses once; state returns to IDLE with busy=0.
3. gold_valid toggled 1,0,1,0 during FILL. Required: wr_en only on valid cycles; fill_cnt holds during gaps; fill completes after exactly 16 accepted bits.
4. map_ready low for 3 cycles at pair 2. Required: rd_addr stays (8,9,10,11) and nrs_valid stays 1 throughout the stall.
5. start during SERVE at pair 1, plus a second start at pair 3 in the same cycle as the final handshake. Required: exactly one follow-on FILL with no IDLE cycle in between; the second start is dropped.
6. rst asserted during FILL at fill_cnt=7, then released, then start. Required: all outputs go to their reset values immediately; the new fill begins at wr_addr=0.

Source files
------------

// File: rtl/nrs_reg_ctrl.sv
// Fill/serve sequencer for the NRS bit register: loads WIDTH_REG Gold bits, then hands the
// mapper one (1r, 1i, 2r, 2i) address set per handshake.
module nrs_reg_ctrl #(
  parameter int unsigned WIDTH_REG = 16,
  parameter int unsigned LINES     = $clog2(WIDTH_REG),
  parameter int unsigned PAIRS     = WIDTH_REG / 4,
  parameter int unsigned PAIR_W    = (PAIRS > 1) ? $clog2(PAIRS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              gold_valid,
  output logic              gold_ready,
  output logic              wr_en,
  output logic [LINES-1:0]  wr_addr,
  output logic              nrs_valid,
  input  logic              map_ready,
  output logic [LINES-1:0]  rd_addr_1r,
  output logic [LINES-1:0]  rd_addr_1i,
  output logic [LINES-1:0]  rd_addr_2r,
  output logic [LINES-1:0]  rd_addr_2i,
  output logic [PAIR_W-1:0] pair_idx,
  output logic              busy,
  output logic              block_done
);

  typedef enum logic [1:0] {StIdle, StFill, StServe} state_e;

  localparam logic [LINES-1:0]  LastBit  = LINES'(WIDTH_REG - 1);
  localparam logic [PAIR_W-1:0] LastPair = PAIR_W'(PAIRS - 1);

  state_e              state_q, state_d;
  logic [LINES-1:0]    fill_cnt_q, fill_cnt_d;
  logic [PAIR_W-1:0]   pair_cnt_q, pair_cnt_d;
  logic                pending_q, pending_d;
  logic                block_done_q, block_done_d;
  logic [LINES-1:0]    rd_base;

  always_comb begin
    state_d      = state_q;
    fill_cnt_d   = fill_cnt_q;
    pair_cnt_d   = pair_cnt_q;
    pending_d    = pending_q;
    block_done_d = 1'b0;
    gold_ready   = 1'b0;
    wr_en        = 1'b0;
    nrs_valid    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StFill;
          fill_cnt_d = '0;
        end
      end
      StFill: begin
        gold_ready = 1'b1;
        wr_en      = gold_valid;
        if (gold_valid) begin
          if (fill_cnt_q == LastBit) begin
            fill_cnt_d = '0;
            pair_cnt_d = '0;
            state_d    = StServe;
          end else begin
            fill_cnt_d = fill_cnt_q + LINES'(1);
          end
        end
      end
      StServe: begin
        nrs_valid = 1'b1;
        if (start) begin
          pending_d = 1'b1;
        end
        if (map_ready) begin
          if (pair_cnt_q == LastPair) begin
            pair_cnt_d   = '0;
            block_done_d = 1'b1;
            // A start landing on the final handshake counts as pending too.
            if (pending_q || start) begin
              pending_d  = 1'b0;
              fill_cnt_d = '0;
              state_d    = StFill;
            end else begin
              state_d = StIdle;
            end
          end else begin
            pair_cnt_d = pair_cnt_q + PAIR_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      fill_cnt_q   <= '0;
      pair_cnt_q   <= '0;
      pending_q    <= 1'b0;
      block_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fill_cnt_q   <= fill_cnt_d;
      pair_cnt_q   <= pair_cnt_d;
      pending_q    <= pending_d;
      block_done_q <= block_done_d;
    end
  end

  assign rd_base    = LINES'({pair_cnt_q, 2'b00});
  assign rd_addr_1r = rd_base;
  assign rd_addr_1i = rd_base + LINES'(1);
  assign rd_addr_2r = rd_base + LINES'(2);
  assign rd_addr_2i = rd_base + LINES'(3);
  assign wr_addr    = fill_cnt_q;
  assign pair_idx   = pair_cnt_q;
  assign busy       = (state_q != StIdle);
  assign block_done = block_done_q;

endmodule

// File: tb/tb_nrs_reg_ctrl.sv
// Directed plus randomized bench for nrs_reg_ctrl, checked against a count-based block model
// and a bench-side emulation of the NRS bit register.
module tb_nrs_reg_ctrl;

  localparam int W = 16;
  localparam int P = W / 4;

  logic       clk, rst, start, gold_valid, map_ready;
  logic       gold_ready, wr_en, nrs_valid, busy, block_done;
  logic [3:0] wr_addr, rd_addr_1r, rd_addr_1i, rd_addr_2r, rd_addr_2i;
  logic [1:0] pair_idx;

  nrs_reg_ctrl #(.WIDTH_REG(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .gold_valid (gold_valid),
    .gold_ready (gold_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .nrs_valid  (nrs_valid),
    .map_ready  (map_ready),
    .rd_addr_1r (rd_addr_1r),
    .rd_addr_1i (rd_addr_1i),
    .rd_addr_2r (rd_addr_2r),
    .rd_addr_2i (rd_addr_2i),
    .pair_idx   (pair_idx),
    .busy       (busy),
    .block_done (block_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: bits still to accept, pairs still to serve, one-deep pending start.
  int          bits_needed, pairs_left;
  bit          pend, exp_done;
  logic [15:0] fill_word, serve_word, next_word;
  logic        regbank [0:15];
  int          accepted;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    bits_needed = 0;
    pairs_left  = 0;
    pend        = 1'b0;
    exp_done    = 1'b0;
  endtask

  task automatic begin_fill();
    bits_needed = W;
    fill_word   = next_word;
    next_word   = 16'($urandom);
  endtask

  task automatic check_outputs();
    int   ep;
    logic filling, serving;
    filling = (bits_needed > 0);
    serving = (pairs_left > 0);
    ep      = serving ? (P - pairs_left) : 0;
    check("busy",       32'(busy),       32'(filling || serving));
    check("gold_ready", 32'(gold_ready), 32'(filling));
    check("wr_en",      32'(wr_en),      32'(filling && gold_valid));
    check("wr_addr",    32'(wr_addr),    filling ? 32'(W - bits_needed) : 32'd0);
    check("nrs_valid",  32'(nrs_valid),  32'(serving));
    check("pair_idx",   32'(pair_idx),   32'(ep));
    check("rd_addr_1r", 32'(rd_addr_1r), 32'(4 * ep));
    check("rd_addr_1i", 32'(rd_addr_1i), 32'(4 * ep + 1));
    check("rd_addr_2r", 32'(rd_addr_2r), 32'(4 * ep + 2));
    check("rd_addr_2i", 32'(rd_addr_2i), 32'(4 * ep + 3));
    check("block_done", 32'(block_done), 32'(exp_done));
  endtask

  // One clock: check just after negedge settling, emulate register write, advance model.
  task automatic do_cycle();
    logic       cap_we;
    logic [3:0] cap_wa;
    logic [3:0] nib;
    int         ep;
    #1;
    check_outputs();
    if (pairs_left > 0 && map_ready) begin
      ep  = P - pairs_left;
      nib = {regbank[rd_addr_2i], regbank[rd_addr_2r], regbank[rd_addr_1i], regbank[rd_addr_1r]};
      check("readback", 32'(nib), 32'(serve_word[4*ep +: 4]));
    end
    cap_we = wr_en;
    cap_wa = wr_addr;
    @(posedge clk);
    if (cap_we) begin
      regbank[cap_wa] = fill_word[W - bits_needed];
      accepted++;
    end
    exp_done = 1'b0;
    if (bits_needed > 0) begin
      if (gold_valid) begin
        bits_needed--;
        if (bits_needed == 0) begin
          pairs_left = P;
          serve_word = fill_word;
        end
      end
    end else if (pairs_left > 0) begin
      if (start) pend = 1'b1;
      if (map_ready) begin
        pairs_left--;
        if (pairs_left == 0) begin
          exp_done = 1'b1;
          if (pend) begin
            pend = 1'b0;
            begin_fill();
          end
        end
      end
    end else if (start) begin
      begin_fill();
    end
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    do_cycle();
    start = 1'b0;
  endtask

  task automatic run_until_valid(output int cycles);
    cycles = 0;
    while (!nrs_valid && cycles < 100) begin
      do_cycle();
      cycles++;
    end
    check("serve_reached", 32'(nrs_valid), 32'd1);
  endtask

  initial begin
    int n;
    rst        = 1'b0;
    start      = 1'b0;
    gold_valid = 1'b0;
    map_ready  = 1'b0;
    accepted   = 0;
    for (int i = 0; i < 16; i++) regbank[i] = 1'b0;
    model_reset();
    next_word = 16'hA5C3;
    fill_word = '0;
    serve_word = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    rst = 1'b1;
    do_cycle();

    // Fill 0xA5C3 with no stalls; nrs_valid 17 cycles after start.
    gold_valid = 1'b1;
    pulse_start();
    run_until_valid(n);
    check("fill_latency", 32'(n + 1), 32'd17);

    // Serve all pairs back to back, then idle.
    map_ready = 1'b1;
    for (int i = 0; i < P; i++) do_cycle();
    map_ready = 1'b0;
    do_cycle();
    check("idle_after_block", 32'(busy), 32'd0);

    // Gappy fill: exactly 16 accepted bits.
    accepted = 0;
    pulse_start();
    for (int i = 0; i < 60 && !nrs_valid; i++) begin
      gold_valid = (i % 2 == 0);
      do_cycle();
    end
    check("accepted_bits", 32'(accepted), 32'd16);

    // Mapper stall at pair 2 for three cycles.
    map_ready = 1'b1;
    do_cycle();
    do_cycle();
    map_ready = 1'b0;
    for (int i = 0; i < 3; i++) do_cycle();
    map_ready = 1'b1;
    do_cycle();
    do_cycle();
    map_ready = 1'b0;
    do_cycle();

    // Pending start at pair 1, dropped second start on the final handshake.
    gold_valid = 1'b1;
    pulse_start();
    run_until_valid(n);
    map_ready = 1'b1;
    do_cycle();
    pulse_start();
    do_cycle();
    pulse_start();
    check("follow_on_fill", 32'(gold_ready), 32'd1);
    run_until_valid(n);
    for (int i = 0; i < P; i++) do_cycle();
    map_ready = 1'b0;
    for (int i = 0; i < 3; i++) do_cycle();
    check("second_start_dropped", 32'(busy), 32'd0);

    // Asynchronous reset mid-fill at fill_cnt 7.
    pulse_start();
    for (int i = 0; i < 7; i++) do_cycle();
    check("pre_reset_addr", 32'(wr_addr), 32'd7);
    rst = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst = 1'b1;
    do_cycle();
    pulse_start();
    run_until_valid(n);
    map_ready = 1'b1;
    for (int i = 0; i < P; i++) do_cycle();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      start      = ($urandom_range(0, 7) == 0);
      gold_valid = ($urandom_range(0, 3) != 0);
      map_ready  = ($urandom_range(0, 1) == 1);
      do_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
